// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: extracts and sign-extends I/S/B/J/U immediates
// to XLEN behind a valid/ready output register with a one-entry skid buffer.
// Optional feature macro: IMMGEN_CSR_ZIMM_EN (imm_src=101 yields the CSR zimm).
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_src,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             illegal
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; valid, once raised, stays high with stable payload until it is taken.

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    localparam logic [2:0] SRC_I    = 3'b000;
    localparam logic [2:0] SRC_S    = 3'b001;
    localparam logic [2:0] SRC_B    = 3'b010;
    localparam logic [2:0] SRC_J    = 3'b011;
    localparam logic [2:0] SRC_U    = 3'b100;
    localparam logic [2:0] SRC_ZIMM = 3'b101;

    function automatic logic [XLEN-1:0] sx32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    logic [XLEN-1:0] dec_imm;
    logic            dec_ill;

    always_comb begin
        dec_imm = '0;
        dec_ill = 1'b0;
        case (imm_src)
            SRC_I: dec_imm = sx32({{20{instr[31]}}, instr[31:20]});
            SRC_S: dec_imm = sx32({{20{instr[31]}}, instr[31:25], instr[11:7]});
            SRC_B: dec_imm = sx32({{19{instr[31]}}, instr[31], instr[7],
                                   instr[30:25], instr[11:8], 1'b0});
            SRC_J: dec_imm = sx32({{11{instr[31]}}, instr[31], instr[19:12],
                                   instr[20], instr[30:21], 1'b0});
            SRC_U: dec_imm = sx32({instr[31:12], 12'b0});
`ifdef IMMGEN_CSR_ZIMM_EN
            SRC_ZIMM: dec_imm = XLEN'(instr[19:15]);
`else
            SRC_ZIMM: dec_ill = 1'b1;
`endif
            default: dec_ill = 1'b1;
        endcase
    end

    logic             ready_live;
    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_ill;
    logic             advance;
    logic             accept;

    // ready_live only masks in_ready during reset; otherwise in_ready tracks the skid.
    assign in_ready = ready_live && !skid_valid;
    assign accept   = in_valid && in_ready;
    assign advance  = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_live <= 1'b0;
            out_valid  <= 1'b0;
            imm        <= '0;
            out_tag    <= '0;
            illegal    <= 1'b0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_tag   <= '0;
            skid_ill   <= 1'b0;
        end else if (flush) begin
            ready_live <= 1'b1;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            ready_live <= 1'b1;
            if (advance) begin
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    imm        <= skid_imm;
                    out_tag    <= skid_tag;
                    illegal    <= skid_ill;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    out_valid <= 1'b1;
                    imm       <= dec_imm;
                    out_tag   <= tag_in;
                    illegal   <= dec_ill;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (accept) begin
                // Output is stalled: park the new item so decode is not lost.
                skid_valid <= 1'b1;
                skid_imm   <= dec_imm;
                skid_tag   <= tag_in;
                skid_ill   <= dec_ill;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: directed format/backpressure/flush/reset cases
// followed by randomized traffic against a field-arithmetic reference model.
module tb_imm_gen_pipe;

    localparam int XLEN  = 32;
    localparam int TAG_W = 8;
    localparam int EW    = XLEN + TAG_W + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [2:0]       imm_src;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] out_tag;
    logic             illegal;

    int checks   = 0;
    int failures = 0;

    logic [EW-1:0] exp_q[$];

    int   rdy_mode  = 0;   // 0: out_ready follows rdy_force, 1: random
    logic rdy_force = 1'b1;

    imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .imm_src(imm_src), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .imm(imm), .out_tag(out_tag), .illegal(illegal)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
        else               out_ready = rdy_force;
    end

    // ---------------- reference model ----------------
    function automatic logic [XLEN-1:0] ref_imm(input logic [31:0] i, input logic [2:0] s,
                                                output logic ill);
        longint     u, v;
        logic [63:0] r;
        u   = longint'({32'h0, i});
        v   = 0;
        ill = 1'b0;
        case (s)
            3'd0: begin
                v = (u >> 20) & 'hFFF;
                if (v >= 2048) v = v - 4096;
            end
            3'd1: begin
                v = ((u >> 25) & 'h7F) * 32 + ((u >> 7) & 'h1F);
                if (v >= 2048) v = v - 4096;
            end
            3'd2: begin
                v = ((u >> 31) & 1) * 4096 + ((u >> 7) & 1) * 2048
                  + ((u >> 25) & 'h3F) * 32 + ((u >> 8) & 'hF) * 2;
                if (v >= 4096) v = v - 8192;
            end
            3'd3: begin
                v = ((u >> 31) & 1) * 1048576 + ((u >> 12) & 'hFF) * 4096
                  + ((u >> 20) & 1) * 2048 + ((u >> 21) & 'h3FF) * 2;
                if (v >= 1048576) v = v - 2097152;
            end
            3'd4: begin
                v = u & 'hFFFFF000;
                if (v >= 64'h80000000) v = v - 64'h100000000;
            end
`ifdef IMMGEN_CSR_ZIMM_EN
            3'd5: v = (u >> 15) & 'h1F;
`endif
            default: begin
                v   = 0;
                ill = 1'b1;
            end
        endcase
        r = 64'(v);
        return r[XLEN-1:0];
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic             held_v = 1'b0;
    logic [XLEN-1:0]  held_imm;
    logic [TAG_W-1:0] held_tag;
    logic             held_ill;

    always @(negedge clk) begin
        if (!rst_n || flush) begin
            held_v = 1'b0;
        end else begin
            if (held_v && out_valid) begin
                chk("stall_imm", 64'(imm), 64'(held_imm));
                chk("stall_tag", 64'(out_tag), 64'(held_tag));
                chk("stall_ill", 64'(illegal), 64'(held_ill));
            end
            if (out_valid && out_ready) begin
                held_v = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got tag 0x%0h expected none", out_tag);
                end else begin
                    logic [EW-1:0] e;
                    e = exp_q.pop_front();
                    chk("out_imm", 64'(imm), 64'(e[XLEN-1:0]));
                    chk("out_tag", 64'(out_tag), 64'(e[XLEN+TAG_W-1:XLEN]));
                    chk("out_ill", 64'(illegal), 64'(e[EW-1]));
                end
            end else if (out_valid) begin
                held_v   = 1'b1;
                held_imm = imm;
                held_tag = out_tag;
                held_ill = illegal;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic drive_item(input logic [31:0] i, input logic [2:0] s,
                              input logic [TAG_W-1:0] t);
        logic            ill;
        logic [XLEN-1:0] m;
        in_valid = 1'b1;
        instr    = i;
        imm_src  = s;
        tag_in   = t;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                m = ref_imm(i, s, ill);
                exp_q.push_back({ill, t, m});
                step();
                in_valid = 1'b0;
                return;
            end
            step();
        end
        checks++;
        failures++;
        $display("FAIL accept_timeout: got no in_ready expected accept of tag 0x%0h", t);
        in_valid = 1'b0;
    endtask

    // Item accepted at the last edge must already be on the output.
    task automatic expect_now(input string name, input logic [XLEN-1:0] e_imm, input logic e_ill);
        @(negedge clk);
        chk({name, "_valid"}, 64'(out_valid), 64'(1));
        chk({name, "_imm"}, 64'(imm), 64'(e_imm));
        chk({name, "_ill"}, 64'(illegal), 64'(e_ill));
        step();
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({name, "_imm"}, 64'(imm), 64'(0));
        chk({name, "_out_tag"}, 64'(out_tag), 64'(0));
        chk({name, "_illegal"}, 64'(illegal), 64'(0));
        chk({name, "_in_ready"}, 64'(in_ready), 64'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        instr     = '0;
        imm_src   = '0;
        tag_in    = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("post_reset_in_ready", 64'(in_ready), 64'(1));
        step();

        // Formats with the consumer always ready.
        drive_item(32'hFFF00093, 3'd0, 8'h10); expect_now("fmt_i", 32'hFFFFFFFF, 1'b0);
        drive_item(32'hFE20AE23, 3'd1, 8'h11); expect_now("fmt_s", 32'hFFFFFFFC, 1'b0);
        drive_item(32'hFE000CE3, 3'd2, 8'h12); expect_now("fmt_b", 32'hFFFFFFF8, 1'b0);
        drive_item(32'h0010006F, 3'd3, 8'h13); expect_now("fmt_j", 32'h00000800, 1'b0);
        drive_item(32'h800000B7, 3'd4, 8'h14); expect_now("fmt_u", 32'h80000000, 1'b0);

        // Reserved encoding flows through, next legal item clears illegal.
        drive_item(32'h12345678, 3'd6, 8'h5A); expect_now("rsvd", 32'h0, 1'b1);
        drive_item(32'h00100093, 3'd0, 8'h5B); expect_now("after_rsvd", 32'h1, 1'b0);

`ifdef IMMGEN_CSR_ZIMM_EN
        drive_item(32'h000F8073, 3'd5, 8'h20); expect_now("zimm", 32'h1F, 1'b0);
`else
        drive_item(32'h000F8073, 3'd5, 8'h20); expect_now("zimm", 32'h0, 1'b1);
`endif

        // Backpressure: tag1 to output, tag2 to skid, tag3 held off.
        rdy_force = 1'b0;
        step();
        in_valid = 1'b1; instr = 32'h00500093; imm_src = 3'd0; tag_in = 8'h01;
        @(negedge clk);
        chk("bp_ready_t1", 64'(in_ready), 64'(1));
        exp_q.push_back({1'b0, 8'h01, 32'h5});
        step();
        instr = 32'hFE20AE23; imm_src = 3'd1; tag_in = 8'h02;
        @(negedge clk);
        chk("bp_ready_t2", 64'(in_ready), 64'(1));
        exp_q.push_back({1'b0, 8'h02, 32'hFFFFFFFC});
        step();
        instr = 32'h0010006F; imm_src = 3'd3; tag_in = 8'h03;
        @(negedge clk);
        chk("bp_ready_t3_held", 64'(in_ready), 64'(0));
        chk("bp_out_tag", 64'(out_tag), 64'(8'h01));
        step();
        rdy_force = 1'b1;
        drive_item(32'h0010006F, 3'd3, 8'h03);
        repeat (4) step();
        chk("bp_drained", 64'(exp_q.size()), 64'(0));

        // Flush with both entries occupied.
        rdy_force = 1'b0;
        step();
        drive_item(32'h00A00093, 3'd0, 8'h31);
        drive_item(32'h00B00093, 3'd0, 8'h32);
        @(negedge clk);
        chk("full_out_valid", 64'(out_valid), 64'(1));
        chk("full_in_ready", 64'(in_ready), 64'(0));
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        chk("flush_in_ready", 64'(in_ready), 64'(1));
        step();
        rdy_force = 1'b1;
        drive_item(32'h7FF00093, 3'd0, 8'h33); expect_now("post_flush", 32'h7FF, 1'b0);

        // Reset in the middle of a stalled stream.
        rdy_force = 1'b0;
        step();
        drive_item(32'hFFF00093, 3'd0, 8'h41);
        drive_item(32'h800000B7, 3'd4, 8'h42);
        rst_n = 1'b0;
        step();
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs("mid_reset");
        step();
        rst_n     = 1'b1;
        rdy_force = 1'b1;
        step();
        drive_item(32'h0010006F, 3'd3, 8'h43); expect_now("post_reset", 32'h800, 1'b0);

        // Randomized traffic with random consumer stalls.
        rdy_mode = 1;
        for (int k = 0; k < 300; k++) begin
            drive_item($urandom, 3'($urandom_range(0, 7)), 8'($urandom));
            if ($urandom_range(0, 3) == 0) step();
        end
        rdy_mode  = 0;
        rdy_force = 1'b1;
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) step();
        chk("final_drain", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish before limit");
        $fatal(1, "global timeout");
    end

endmodule
